chi_plane_serial: RTL and testbench
===================================

// Module: chi_plane_serial
// PURPOSE
//  Sequential, parametrised chi (non-linear) step for the Keccak-f round datapath.
//  Latches a full 5x5 state through a valid/ready handshake and applies chi over 5/PLANES_PER_CYC cycles.
//  Each cycle it processes PLANES_PER_CYC y-planes in place, trading area for latency.
//  Sits between rho/pi and iota in the round pipeline; iota can optionally be fused in.
// PARAMETERS
//  LANE_W          64  lane width w (1,2,4,...,64); supports Keccak-f[25*w]
//  PLANES_PER_CYC  1   y-planes processed per cycle; legal {1,5}; NPASS = 5/PLANES_PER_CYC
// PORTS
//  clk        in   1               clock, rising edge
//  rst        in   1               asynchronous, active-high reset
//  in_valid   in   1               state_in valid
//  in_ready   out  1               block accepts state_in this cycle
//  state_in   in   [5][5][LANE_W]  input state, indexed [x][y][z]
//  out_valid  out  1               state_out valid
//  out_ready  in   1               downstream accepts state_out
//  state_out  out  [5][5][LANE_W]  result state, driven from work register
//  busy       out  1               high while in BUSY
//  rc_in      in   LANE_W          round constant, sampled on accept (CHI_IOTA_FUSE_EN only)
// BEHAVIOUR
//  - Chi: A'[x][y] = A[x][y] ^ (~A[(x+1)%5][y] & A[(x+2)%5][y]), bitwise over z.
//  - FSM chi_fsm_e: IDLE -> BUSY on accept; BUSY -> DONE when cnt==NPASS-1; DONE -> IDLE on out_ready & !in_valid.
//  - DONE -> BUSY on out_ready & in_valid (back-to-back accept and release in the same cycle).
//  - Accept = in_valid & in_ready; in_ready = (st==IDLE) | (st==DONE & out_ready). Accept loads work reg, clears cnt.
//  - BUSY: cnt (3 bits) selects planes y = cnt*PPC .. cnt*PPC+PPC-1; those lanes are overwritten with chi.
//  - Planes are independent, so in-place update is exact. cnt increments and resets to 0 on leaving BUSY.
//  - Latency: out_valid asserts exactly NPASS cycles after the accept edge (5 for PPC=1, 1 for PPC=5).
//  - out_valid = (st==DONE); state_out is held stable while out_valid & !out_ready.
//  - busy = (st==BUSY). in_valid during BUSY is ignored (in_ready=0), never queued.
//  - Reset (async, any state incl. mid-BUSY): st=IDLE, cnt=0, work reg=0, rc reg=0.
//    Outputs: out_valid=0, in_ready=1 (after release), busy=0, state_out=0.
//  - Illegal PLANES_PER_CYC or LANE_W is rejected with an elaboration-time $error.
// CONFIGURATION
//  CHI_IOTA_FUSE_EN defined: rc_in port exists and is latched on accept.
//    rc is XORed into lane [0][0] in the same cycle plane y=0 is processed; output = iota(chi(A)).
//  CHI_IOTA_FUSE_EN undefined: no rc_in port, no rc register; output = chi(A) only.
// STRUCTURE
//  keccak_pkg: ROW_SIZE, COL_SIZE, LANE_SIZE (existing); add chi_fsm_e {IDLE,BUSY,DONE}.
//  keccak_pkg: add function chi_lane(a0,a1,a2) returning a0 ^ (~a1 & a2).
//  Sub-module chi_plane: combinational 5-lane chi for one y-plane, instantiated PLANES_PER_CYC times.
//  This top holds the FSM, cnt, work register, plane mux/demux and the optional rc register.
// TESTING
//  1. all-zero state, PPC=1 -> out_valid exactly 5 cycles after accept; all lanes 0.
//  2. lanes [1][y]=all-ones, others 0 -> out[1][y]=out[4][y]=all-ones, others 0, every y.
//  3. all-ones state -> all-ones out; random states vs software chi model, 1000 vectors, PPC=1 and PPC=5.
//  4. out_ready low 10 cycles in DONE -> state_out stable, in_ready=0.
//     Then out_ready=1 with in_valid=1 -> new accept same cycle, next out_valid after 5 cycles.
//  5. assert rst at cnt==2 -> next cycle st=IDLE, out_valid=0, state_out=0.
//     Next accept completes with correct result after 5 cycles.
//  6. CHI_IOTA_FUSE_EN, zero state, rc_in=64'h0000_0000_0000_8082 -> out[0][0]=64'h8082, all else 0.
//     Without the macro, same state -> all 0.

Source files
------------

// File: rtl/keccak_pkg.sv
// Keccak shared definitions: state geometry, chi FSM states and the chi lane function.
package keccak_pkg;

    localparam int unsigned ROW_SIZE  = 5;
    localparam int unsigned COL_SIZE  = 5;
    localparam int unsigned LANE_SIZE = 64;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } chi_fsm_e;

    function automatic logic [LANE_SIZE-1:0] chi_lane(input logic [LANE_SIZE-1:0] a0,
                                                      input logic [LANE_SIZE-1:0] a1,
                                                      input logic [LANE_SIZE-1:0] a2);
        return a0 ^ (~a1 & a2);
    endfunction

endpackage

// File: rtl/chi_plane.sv
// Combinational chi over the five lanes of one y-plane.
module chi_plane
    import keccak_pkg::*;
#(
    parameter int unsigned LANE_W = 64
) (
    input  logic [ROW_SIZE-1:0][LANE_W-1:0] plane_in,
    output logic [ROW_SIZE-1:0][LANE_W-1:0] plane_out
);

    for (genvar x = 0; x < ROW_SIZE; x++) begin : g_lane
        assign plane_out[x] = LANE_W'(chi_lane(LANE_SIZE'(plane_in[x]),
                                               LANE_SIZE'(plane_in[(x + 1) % ROW_SIZE]),
                                               LANE_SIZE'(plane_in[(x + 2) % ROW_SIZE])));
    end

endmodule

// File: rtl/chi_plane_serial.sv
// Serial chi step: latches a 5x5 state and applies chi PLANES_PER_CYC planes per cycle.
// Optional iota fusion enabled by defining CHI_IOTA_FUSE_EN.
module chi_plane_serial
    import keccak_pkg::*;
#(
    parameter int unsigned LANE_W         = 64,
    parameter int unsigned PLANES_PER_CYC = 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_W-1:0] state_in,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_W-1:0] state_out,
    output logic                                        busy
`ifdef CHI_IOTA_FUSE_EN
    ,
    input  logic [LANE_W-1:0]                           rc_in
`endif
);

    localparam int unsigned NPASS = (PLANES_PER_CYC == 5) ? 1 : 5;
    localparam logic [2:0]  LAST  = 3'(NPASS - 1);

    if (!(PLANES_PER_CYC == 1 || PLANES_PER_CYC == 5)) begin : g_bad_ppc
        $error("chi_plane_serial: PLANES_PER_CYC must be 1 or 5");
    end
    if (!(LANE_W >= 1 && LANE_W <= 64 && (LANE_W & (LANE_W - 1)) == 0)) begin : g_bad_lane
        $error("chi_plane_serial: LANE_W must be a power of two in 1..64");
    end

    chi_fsm_e st_q, st_d;
    logic [2:0] cnt_q, cnt_d;
    logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_W-1:0] work_q, work_d;
    logic accept;
    logic [LANE_W-1:0] rc_mix;

    logic [PLANES_PER_CYC-1:0][2:0]                    y_sel;
    logic [PLANES_PER_CYC-1:0][ROW_SIZE-1:0][LANE_W-1:0] pl_in, pl_out;

`ifdef CHI_IOTA_FUSE_EN
    logic [LANE_W-1:0] rc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rc_q <= '0;
        end else if (accept) begin
            rc_q <= rc_in;
        end
    end

    assign rc_mix = rc_q;
`else
    assign rc_mix = '0;
`endif

    // Plane mux: pass p handles plane cnt*PPC + p.
    always_comb begin
        y_sel = '0;
        pl_in = '0;
        for (int p = 0; p < PLANES_PER_CYC; p++) begin
            y_sel[p] = 3'(int'(cnt_q) * int'(PLANES_PER_CYC) + p);
            for (int x = 0; x < ROW_SIZE; x++) begin
                pl_in[p][x] = work_q[x][y_sel[p]];
            end
        end
    end

    for (genvar p = 0; p < PLANES_PER_CYC; p++) begin : g_plane
        chi_plane #(
            .LANE_W(LANE_W)
        ) u_chi_plane (
            .plane_in (pl_in[p]),
            .plane_out(pl_out[p])
        );
    end

    always_comb begin
        work_d = work_q;
        if (accept) begin
            work_d = state_in;
        end else if (st_q == BUSY) begin
            for (int p = 0; p < PLANES_PER_CYC; p++) begin
                for (int x = 0; x < ROW_SIZE; x++) begin
                    work_d[x][y_sel[p]] = pl_out[p][x];
                end
                if (y_sel[p] == 3'd0) begin
                    work_d[0][0] = pl_out[p][0] ^ rc_mix;
                end
            end
        end
    end

    always_comb begin
        cnt_d = '0;
        if (!accept && st_q == BUSY && cnt_q != LAST) begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= IDLE;
            cnt_q  <= '0;
            work_q <= '0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            work_q <= work_d;
        end
    end

    always_comb begin
        st_d = st_q;
        case (st_q)
            IDLE: if (in_valid) st_d = BUSY;
            BUSY: if (cnt_q == LAST) st_d = DONE;
            DONE: if (out_ready) st_d = in_valid ? BUSY : IDLE;
            default: st_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (st_q == IDLE) | ((st_q == DONE) & out_ready);
        out_valid = (st_q == DONE);
        busy      = (st_q == BUSY);
        accept    = in_valid & in_ready;
    end

    assign state_out = work_q;

endmodule

// File: tb/tb_chi_plane_serial.sv
// Scoreboard bench for chi_plane_serial: PPC=1 and PPC=5 instances against a chi reference model.
module tb_chi_plane_serial;

    typedef logic [4:0][4:0][63:0] st_t;
    typedef struct {
        st_t exp;
        int  acc;
    } tx_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic clk = 0;
    logic rst = 1, rst5 = 1;
    logic iv1 = 0, ir1, ov1, or1 = 0, bz1;
    logic iv5 = 0, ir5, ov5, or5 = 0, bz5;
    st_t  si1 = '0, so1, si5 = '0, so5;
    logic [63:0] rc1 = '0, rc5 = '0;
    logic hold_low = 0;
    logic first1 = 1, first5 = 1;
    logic done5 = 0;
    tx_t  q1[$], q5[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    chi_plane_serial #(.LANE_W(64), .PLANES_PER_CYC(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .state_in(si1),
        .out_valid(ov1), .out_ready(or1), .state_out(so1), .busy(bz1)
`ifdef CHI_IOTA_FUSE_EN
        , .rc_in(rc1)
`endif
    );

    chi_plane_serial #(.LANE_W(64), .PLANES_PER_CYC(5)) u_dut5 (
        .clk(clk), .rst(rst5), .in_valid(iv5), .in_ready(ir5), .state_in(si5),
        .out_valid(ov5), .out_ready(or5), .state_out(so5), .busy(bz5)
`ifdef CHI_IOTA_FUSE_EN
        , .rc_in(rc5)
`endif
    );

    function automatic st_t model(input st_t a, input logic [63:0] rc);
        st_t r;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                r[x][y] = a[x][y] ^ (~a[(x + 1) % 5][y] & a[(x + 2) % 5][y]);
`ifdef CHI_IOTA_FUSE_EN
        r[0][0] = r[0][0] ^ rc;
`endif
        return r;
    endfunction

    function automatic st_t rand_state();
        st_t s;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                s[x][y] = {$urandom, $urandom};
        return s;
    endfunction

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", n, got, exp);
        end
    endtask

    task automatic chk_st(input string n, input st_t got, input st_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++)
                    if (got[x][y] !== exp[x][y])
                        $display("FAIL %s lane[%0d][%0d] got %h exp %h at cycle %0d",
                                 n, x, y, got[x][y], exp[x][y], cyc);
        end
    endtask

    task automatic send1(input st_t s, input logic [63:0] rc);
        int t = 0;
        @(negedge clk);
        iv1 = 1; si1 = s; rc1 = rc;
        #1;
        while (!ir1 && t < 300) begin
            @(negedge clk); #1; t++;
        end
        if (!ir1) chk("send1_timeout", 64'(ir1), 64'd1);
        else q1.push_back('{model(s, rc), cyc + 1});
        @(posedge clk); #1;
        iv1 = 0;
    endtask

    task automatic send5(input st_t s, input logic [63:0] rc);
        int t = 0;
        @(negedge clk);
        iv5 = 1; si5 = s; rc5 = rc;
        #1;
        while (!ir5 && t < 300) begin
            @(negedge clk); #1; t++;
        end
        if (!ir5) chk("send5_timeout", 64'(ir5), 64'd1);
        else q5.push_back('{model(s, rc), cyc + 1});
        @(posedge clk); #1;
        iv5 = 0;
    endtask

    // out_ready changes just after the active edge so handshakes are stable at negedge
    initial forever begin
        @(posedge clk); #2;
        or1 = hold_low ? 1'b0 : ($urandom_range(3) != 0);
        or5 = ($urandom_range(2) != 0);
    end

    always @(negedge clk) begin
        if (!rst && ov1) begin
            if (q1.size() == 0) begin
                chk("dut1_unexpected_out", 64'(ov1), 64'd0);
            end else begin
                chk_st("dut1_data", so1, q1[0].exp);
                chk("dut1_in_ready_done", 64'(ir1), 64'(or1));
                if (first1) begin
                    chk("dut1_latency", 64'(cyc - q1[0].acc), 64'd5);
                    first1 = 0;
                end
                if (or1) begin
                    void'(q1.pop_front());
                    first1 = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst5 && ov5) begin
            if (q5.size() == 0) begin
                chk("dut5_unexpected_out", 64'(ov5), 64'd0);
            end else begin
                chk_st("dut5_data", so5, q5[0].exp);
                if (first5) begin
                    chk("dut5_latency", 64'(cyc - q5[0].acc), 64'd1);
                    first5 = 0;
                end
                if (or5) begin
                    void'(q5.pop_front());
                    first5 = 1;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // PPC=5 stream
    initial begin
        st_t s;
        repeat (3) @(posedge clk);
        #1 rst5 = 0;
        send5('1, 64'h0);
        for (int i = 0; i < 300; i++) begin
            s = rand_state();
            send5(s, {$urandom, $urandom});
        end
        done5 = 1;
    end

    initial begin
        st_t s;
        int  t;
        #1;
        chk("reset_out_valid", 64'(ov1), 64'd0);
        chk("reset_busy", 64'(bz1), 64'd0);
        chk("reset_in_ready", 64'(ir1), 64'd1);
        chk_st("reset_state_out", so1, '0);
        repeat (3) @(posedge clk);
        #1 rst = 0;

        send1('0, 64'h0000_0000_0000_8082);
        for (int y = 0; y < 5; y++) begin
            s = '0;
            s[1][y] = '1;
            send1(s, 64'h0);
        end
        s = '0;
        for (int y = 0; y < 5; y++) s[1][y] = '1;
        send1(s, 64'h0);
        send1('1, 64'h0);

        // Stall in DONE, then release with a new input in the same cycle
        hold_low = 1;
        fork
            begin
                repeat (20) @(posedge clk);
                hold_low = 0;
            end
        join_none
        send1(rand_state(), 64'h0);
        send1(rand_state(), 64'h1);

        // Reset in the middle of BUSY (cnt==2)
        t = 0;
        while (q1.size() > 0 && t < 500) begin @(negedge clk); t++; end
        send1(rand_state(), 64'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1;
        q1.delete();
        first1 = 1;
        #1;
        chk("midreset_out_valid", 64'(ov1), 64'd0);
        chk("midreset_busy", 64'(bz1), 64'd0);
        chk("midreset_in_ready", 64'(ir1), 64'd1);
        chk_st("midreset_state_out", so1, '0);
        @(negedge clk);
        rst = 0;
        send1(rand_state(), 64'h8000_0000_0000_8008);

        for (int i = 0; i < 1000; i++) begin
            s = rand_state();
            send1(s, {$urandom, $urandom});
        end

        t = 0;
        while ((q1.size() > 0 || !done5 || q5.size() > 0) && t < 5000) begin
            @(negedge clk); t++;
        end
        chk("drain_q1", 64'(q1.size()), 64'd0);
        chk("drain_q5", 64'(q5.size()), 64'd0);
        chk("drain_done5", 64'(done5), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
